div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Iterative 64-bit unsigned restoring divider controller for the sequential processor's execute stage.
- Runs one restoring step per cycle on a single 64-bit SUB subtractor instance, 64 steps per divide.
- Valid/ready handshake on both the operand side and the result side, so the execute-stage control can stall on it.

Parameters:
- WIDTH, 64, operand width; fixed at 64 to match the SUB instance.
- CNT_W, 7, step counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  operands presented.
- start_ready  out  1  controller can accept operands.
- dividend  in  64  unsigned dividend.
- divisor  in  64  unsigned divisor.
- res_valid  out  1  quotient/remainder valid.
- res_ready  in  1  consumer takes the result.
- quotient  out  64  result quotient.
- remainder  out  64  result remainder.
- div_zero  out  1  divisor was zero for this result.

Behaviour:
- Reset: rst_n low forces the following asynchronously, overriding everything including mid-CALC: state=IDLE, quotient=0, remainder=0, cnt=0, res_valid=0, div_zero=0, start_ready=1.
- States: IDLE, CALC, DONE. start_ready = (state==IDLE). res_valid = (state==DONE).
- IDLE:
  - Operands are accepted at a clock edge where start_valid && start_ready.
  - divisor!=0: rem<=0, quo<=dividend, cnt<=0, div_zero<=0, go to CALC.
  - divisor==0: quotient<=all ones, remainder<=dividend, div_zero<=1, go to DONE. res_valid is high one cycle after accept.
- CALC step, one per cycle:
  - shifted = {rem, quo[63]}, 65 bits.
  - SUB computes shifted[63:0] - divisor; cout=1 means no borrow.
  - ok = rem[63] | cout. rem[63] covers the 65-bit overflow case.
  - rem <= ok ? diff : shifted[63:0].
  - quo <= {quo[62:0], ok}.
  - cnt <= cnt+1. After the step taken with cnt==63, go to DONE.
- Latency: accept at edge T; steps at edges T+1..T+64; res_valid high from T+64 onward. The last step's edge also enters DONE.
- DONE:
  - quotient, remainder and div_zero are held stable while res_valid && !res_ready.
  - res_ready high: go to IDLE at the next edge. res_valid drops and start_ready rises after that edge.
  - No back-to-back overlap: operands are never accepted in DONE or CALC. Minimum spacing is 66 cycles per divide.
- start_valid during CALC/DONE is ignored; the requester must hold its operands until start_ready.
- Operands are sampled only at acceptance. Changes to the dividend/divisor inputs after acceptance have no effect.
- Output invariant: quotient*divisor + remainder == dividend and remainder < divisor, for divisor != 0.

Decomposition:
- Shared package (div_pkg):
  - WIDTH=64, DIV_STEPS=64.
  - State encoding constants: S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
  - DZ_QUOTIENT = all ones.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next_rem, next_quo.
  - Instantiates SUB internally.
- div_seq_ctrl holds the FSM, counter, registers and handshake.

Test Plan:
- 100 / 7, res_ready tied high -> res_valid rises exactly 64 cycles after accept; quotient=14, remainder=2, div_zero=0.
- 0xFFFFFFFFFFFFFFFF / 0x8000000000000001 -> quotient=1, remainder=0x7FFFFFFFFFFFFFFE. Exercises the rem[63] overflow path.
- 42 / 0 -> res_valid one cycle after accept; quotient=0xFFFFFFFFFFFFFFFF, remainder=42, div_zero=1.
- 0xFFFFFFFFFFFFFFFF / 1, res_ready held low 10 cycles in DONE with start_valid pulsed -> outputs stable (quotient=all ones, remainder=0); start_ready=0 throughout; the new request is not taken until one cycle after the res_ready handshake.
- Start 1000 / 3, drop rst_n at step 30 -> immediately res_valid=0, quotient=0, start_ready=1. After release, 9 / 3 -> quotient=3, remainder=0 at accept+64.
- Random regression, 1000 pairs including divisor > dividend -> check the quotient/remainder identity and remainder < divisor on every result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative restoring divider.
package div_pkg;

   localparam int WIDTH     = 64;
   localparam int DIV_STEPS = 64;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] DZ_QUOTIENT = {WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step
   import div_pkg::*;
(
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] next_rem,
   output logic [WIDTH-1:0] next_quo
);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] diff;
   logic             cout;
   logic             ok;

   // Low 64 bits of {rem, quo[63]}; the dropped top bit is rem[63].
   assign shifted = {rem[WIDTH-2:0], quo[WIDTH-1]};

   // SUB: a - b as a + ~b + 1, carry-out high means no borrow.
   assign {cout, diff} = {1'b0, shifted} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};

   // A set rem[63] means the 65-bit shifted value always exceeds the divisor.
   assign ok       = rem[WIDTH-1] | cout;
   assign next_rem = ok ? diff : shifted;
   assign next_quo = {quo[WIDTH-2:0], ok};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential 64-bit unsigned restoring divider: one step per cycle, 64 steps,
// valid/ready handshakes on the operand and result sides.
module div_seq_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = div_pkg::WIDTH,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   div_step u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               dvs_d = divisor;
               if (divisor == '0) begin
                  quo_d   = DZ_QUOTIENT;
                  rem_d   = dividend;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  quo_d   = dividend;
                  rem_d   = '0;
                  cnt_d   = '0;
                  dz_d    = 1'b0;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            quo_d = step_quo;
            rem_d = step_rem;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign start_ready = (state_q == S_IDLE);
   assign res_valid   = (state_q == S_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_zero    = dz_q;

endmodule
